// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit time-multiplexed seven-segment scanner
//
// Holds a 16-bit hex value plus four decimal-point flags and scans them
// onto a common-anode display one digit per slot, digit 0 -> 1 -> 2 -> 3.
// New values are staged in a shadow register and committed only at a
// frame boundary so a frame is never torn.
//
// Optional feature macro: SEG_SCAN_LEAD_ZERO_BLANK_EN
//   defined   - leading-zero digits (3, 2, 1) are blanked for their slot
//   undefined - all four digits are always shown
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   value      in  16   hex value to show, digit 0 is value[3:0]
//   dp_in      in   4   decimal-point request per digit, active-high
//   load       in   1   strobe capturing value and dp_in
//   digit      out  4   nibble of the selected digit, to segment decoder
//   an         out  4   anode enables, active-low
//   dp         out  1   decimal-point segment, active-low
//   frame_done out  1   one-cycle pulse after each frame boundary

module seg_scan_mux #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned GUARD_TICKS     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] GUARD    = CW'(GUARD_TICKS);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [15:0]   active_val;
    logic [3:0]    active_dp;
    logic          pending;

    logic slot_end;
    logic frame_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;

            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end

            if (frame_end) begin
                // A load on the boundary edge bypasses the shadow so it is
                // shown in the very next frame; nothing is left pending.
                if (load) begin
                    active_val <= value;
                    active_dp  <= dp_in;
                    pending    <= 1'b0;
                end else if (pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                    pending    <= 1'b0;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic blank;

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (active_val[15:12] == 4'h0);
            2'd2:    blank = (active_val[15:8]  == 8'h00);
            2'd1:    blank = (active_val[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    logic guard;
    assign guard = (cnt < GUARD);

    always_comb begin
        digit = active_val[{idx, 2'b00} +: 4];
        an    = 4'b1111;
        dp    = 1'b1;
        if (!guard && !blank) begin
            an = ~(4'b0001 << idx);
            dp = ~active_dp[idx];
        end
    end

endmodule
